// File: rtl/rv32_if_pkg.sv
// ============================================================================
//  Module      : rv32_if_pkg
//  Description : Shared encodings and constants for the RV32IM fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_if_pkg;

    localparam int unsigned c_state_w = 1;

    typedef logic [c_state_w-1:0] fetch_state_t;

    localparam fetch_state_t c_st_fetch = 1'b0;
    localparam fetch_state_t c_st_drain = 1'b1;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;
    localparam logic [31:0] c_pc_incr   = 32'd4;

    // Instructions are word aligned; low address bits are never honoured.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_pc_unit.sv
// ============================================================================
//  Module      : if_pc_unit
//  Description : Program counter register with redirect/hold/advance priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_pc_unit
    import rv32_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_hold,
    input  logic        i_fetch_done,
    input  logic        i_draining,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_pc_freeze;

    assign w_pc_freeze = i_hold | ~i_fetch_done | i_draining;

    // A redirect always wins, even over a load-use hold or an outstanding drain.
    always_comb begin
        w_pc_next = r_pc;
        if (i_branch_taken) begin
            w_pc_next = align_word(i_branch_target);
        end else if (!w_pc_freeze) begin
            w_pc_next = r_pc + c_pc_incr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
//  Module      : if_fetch_stage
//  Description : RV32IM instruction fetch with redirect squash and drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import rv32_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HOLD,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] IMEM_INSTRUCTION,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic        IF_BUSYWAIT
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_drain_addr;
    logic [31:0]  w_pc;
    logic         w_in_fetch;
    logic         w_in_drain;
    logic         w_fetch_done;
    logic         w_drain_capture;

    assign w_in_fetch      = (r_state == c_st_fetch);
    assign w_in_drain      = (r_state == c_st_drain);
    assign w_fetch_done    = w_in_fetch & ~IMEM_BUSYWAIT;
    assign w_drain_capture = w_in_fetch & BRANCH_TAKEN & IMEM_BUSYWAIT;

    if_pc_unit #(
        .RESET_PC        (RESET_PC)
    ) u_pc_unit (
        .clk             (CLK),
        .rst_n           (RESET),
        .i_branch_taken  (BRANCH_TAKEN),
        .i_branch_target (BRANCH_TARGET),
        .i_hold          (HOLD),
        .i_fetch_done    (w_fetch_done),
        .i_draining      (w_in_drain),
        .o_pc            (w_pc)
    );

    // The memory cannot abandon an access, so the wrong-path address is kept
    // on IMEM_ADDR until it finishes; later redirects only move the PC.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= c_st_fetch;
            r_drain_addr <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            if (w_drain_capture) begin
                r_drain_addr <= w_pc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_fetch: begin
                if (w_drain_capture) begin
                    w_state_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (!IMEM_BUSYWAIT) begin
                    w_state_next = c_st_fetch;
                end
            end
            default: w_state_next = c_st_fetch;
        endcase
    end

    always_comb begin
        IMEM_READ      = 1'b0;
        IMEM_ADDR      = w_pc;
        IF_PC          = RESET_PC;
        IF_INSTRUCTION = NOP_INSTR;
        IF_BUSYWAIT    = 1'b0;
        if (RESET) begin
            IMEM_READ = 1'b1;
            IF_PC     = w_pc;
            case (r_state)
                c_st_fetch: begin
                    IMEM_ADDR = w_pc;
                    if (w_fetch_done && !BRANCH_TAKEN) begin
                        IF_INSTRUCTION = IMEM_INSTRUCTION;
                    end
                    // A redirect releases the stall so the branch can leave EX.
                    IF_BUSYWAIT = IMEM_BUSYWAIT & ~BRANCH_TAKEN;
                end
                c_st_drain: begin
                    IMEM_ADDR = r_drain_addr;
                end
                default: begin
                    IMEM_ADDR = w_pc;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Directed vector bench for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        HOLD;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_INSTRUCTION;
    logic        IMEM_BUSYWAIT;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTRUCTION;
    logic        IF_BUSYWAIT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hold;
        logic        br;
        logic [31:0] tgt;
        logic        busy;
        logic [31:0] instr;
        logic        e_read;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_bw;
    } vec_t;

    vec_t vecs[$];

    if_fetch_stage #(
        .RESET_PC         (32'h0000_0000),
        .NOP_INSTR        (32'h0000_0013)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .HOLD             (HOLD),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_TARGET    (BRANCH_TARGET),
        .IMEM_INSTRUCTION (IMEM_INSTRUCTION),
        .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
        .IMEM_READ        (IMEM_READ),
        .IMEM_ADDR        (IMEM_ADDR),
        .IF_PC            (IF_PC),
        .IF_INSTRUCTION   (IF_INSTRUCTION),
        .IF_BUSYWAIT      (IF_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic hold, input logic br, input logic [31:0] tgt,
                       input logic busy, input logic [31:0] instr,
                       input logic e_read, input logic [31:0] e_addr,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_bw);
        vec_t v;
        v.hold = hold; v.br = br; v.tgt = tgt; v.busy = busy; v.instr = instr;
        v.e_read = e_read; v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_bw = e_bw;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic hold, input logic br, input logic [31:0] tgt,
                         input logic busy, input logic [31:0] instr);
        HOLD = hold; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        IMEM_BUSYWAIT = busy; IMEM_INSTRUCTION = instr;
    endtask

    task automatic check_outs(input string tag, input logic e_read, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_bw);
        chk({tag, " read"},  {31'd0, IMEM_READ},   {31'd0, e_read});
        chk({tag, " addr"},  IMEM_ADDR,            e_addr);
        chk({tag, " pc"},    IF_PC,                e_pc);
        chk({tag, " instr"}, IF_INSTRUCTION,       e_instr);
        chk({tag, " busy"},  {31'd0, IF_BUSYWAIT}, {31'd0, e_bw});
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);

        //   hold br  target        busy instr         read addr          pc            instr         bw
        // sequential zero-wait fetch
        add(0, 0, 32'h0,          0, 32'hA000_0000, 1, 32'h0000_0000, 32'h0000_0000, 32'hA000_0000, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0004, 1, 32'h0000_0004, 32'h0000_0004, 32'hA000_0004, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0008, 1, 32'h0000_0008, 32'h0000_0008, 32'hA000_0008, 0);
        add(0, 0, 32'h0,          0, 32'hA000_000C, 1, 32'h0000_000C, 32'h0000_000C, 32'hA000_000C, 0);
        // three busy cycles at 0x10
        add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 32'h0000_0010, 32'h0000_0010, c_nop,         1);
        add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 32'h0000_0010, 32'h0000_0010, c_nop,         1);
        add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 32'h0000_0010, 32'h0000_0010, c_nop,         1);
        add(0, 0, 32'h0,          0, 32'hA000_0010, 1, 32'h0000_0010, 32'h0000_0010, 32'hA000_0010, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0014, 1, 32'h0000_0014, 32'h0000_0014, 32'hA000_0014, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0018, 1, 32'h0000_0018, 32'h0000_0018, 32'hA000_0018, 0);
        add(0, 0, 32'h0,          0, 32'hA000_001C, 1, 32'h0000_001C, 32'h0000_001C, 32'hA000_001C, 0);
        // redirect on a completing fetch, then a misaligned target
        add(0, 1, 32'h0000_0100,  0, 32'hA000_0020, 1, 32'h0000_0020, 32'h0000_0020, c_nop,         0);
        add(0, 1, 32'h0000_0033,  0, 32'hA000_0100, 1, 32'h0000_0100, 32'h0000_0100, c_nop,         0);
        // redirect during busywait -> drain, second redirect while draining
        add(0, 1, 32'h0000_0200,  1, 32'hDEAD_BEEF, 1, 32'h0000_0030, 32'h0000_0030, c_nop,         0);
        add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 32'h0000_0030, 32'h0000_0200, c_nop,         0);
        add(0, 1, 32'h0000_0240,  1, 32'hDEAD_BEEF, 1, 32'h0000_0030, 32'h0000_0200, c_nop,         0);
        add(0, 0, 32'h0,          0, 32'hA000_0030, 1, 32'h0000_0030, 32'h0000_0240, c_nop,         0);
        add(0, 0, 32'h0,          0, 32'hA000_0240, 1, 32'h0000_0240, 32'h0000_0240, 32'hA000_0240, 0);
        // redirect overrides hold
        add(1, 1, 32'h0000_0040,  0, 32'hA000_0244, 1, 32'h0000_0244, 32'h0000_0244, c_nop,         0);
        // hold two cycles at 0x40
        add(1, 0, 32'h0,          0, 32'hA000_0040, 1, 32'h0000_0040, 32'h0000_0040, 32'hA000_0040, 0);
        add(1, 0, 32'h0,          0, 32'hA000_0040, 1, 32'h0000_0040, 32'h0000_0040, 32'hA000_0040, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0040, 1, 32'h0000_0040, 32'h0000_0040, 32'hA000_0040, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0044, 1, 32'h0000_0044, 32'h0000_0044, 32'hA000_0044, 0);
        // wrap-around at the top of the address space
        add(0, 1, 32'hFFFF_FFFC,  0, 32'hA000_0048, 1, 32'h0000_0048, 32'h0000_0048, c_nop,         0);
        add(0, 0, 32'h0,          0, 32'h1234_5678, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1234_5678, 0);
        add(0, 0, 32'h0,          0, 32'hA000_0000, 1, 32'h0000_0000, 32'h0000_0000, 32'hA000_0000, 0);

        // Reset held low across clock edges
        @(negedge CLK);
        check_outs("rst0", 1'b0, 32'h0, 32'h0, c_nop, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge CLK);
        check_outs("rst1", 1'b0, 32'h0, 32'h0, c_nop, 1'b0);

        @(posedge CLK);
        #1;
        RESET = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) begin
                @(posedge CLK);
                #1;
            end
            drive(vecs[i].hold, vecs[i].br, vecs[i].tgt, vecs[i].busy, vecs[i].instr);
            @(negedge CLK);
            check_outs($sformatf("v%0d", i), vecs[i].e_read, vecs[i].e_addr,
                       vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_bw);
        end

        // PC now 0x4: busywait, redirect into drain, then async reset mid-drain
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge CLK);
        check_outs("busy4", 1'b1, 32'h4, 32'h4, c_nop, 1'b1);
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'hDEAD_BEEF);
        @(negedge CLK);
        check_outs("brbusy4", 1'b1, 32'h4, 32'h4, c_nop, 1'b0);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge CLK);
        check_outs("drain300", 1'b1, 32'h4, 32'h300, c_nop, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        check_outs("asyncrst", 1'b0, 32'h0, 32'h0, c_nop, 1'b0);
        @(negedge CLK);
        check_outs("rsthold", 1'b0, 32'h0, 32'h0, c_nop, 1'b0);

        // Release: fetch must restart at RESET_PC in FETCH, not the drain address
        @(posedge CLK); #1;
        RESET = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hA000_0000);
        @(negedge CLK);
        check_outs("rel0", 1'b1, 32'h0, 32'h0, 32'hA000_0000, 1'b0);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hA000_0004);
        @(negedge CLK);
        check_outs("rel1", 1'b1, 32'h4, 32'h4, 32'hA000_0004, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32IM pipeline; sits directly upstream of the IF/ID pipeline register and drives its IF_PC / IF_INSTRUCTION inputs.
- Owns the program counter and issues reads to the instruction memory/cache through a READ/BUSYWAIT handshake.
- Applies taken-branch/jump redirects from EX and squashes wrong-path instructions.
- Produces the stall request that drives the HOLD of all pipeline registers.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) emitted on squash/drain.

Ports:
CLK  input  1  system clock; all state updates on posedge.
RESET  input  1  asynchronous, active-low reset.
HOLD  input  1  load-use stall from hazard unit; freezes PC.
BRANCH_TAKEN  input  1  EX-stage redirect request.
BRANCH_TARGET  input  32  redirect address; bits[1:0] forced to 0 internally.
IMEM_INSTRUCTION  input  32  read data, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
IMEM_BUSYWAIT  input  1  memory access in progress.
IMEM_READ  output  1  fetch request.
IMEM_ADDR  output  32  fetch address; must stay stable while IMEM_BUSYWAIT=1.
IF_PC  output  32  PC of instruction on IF_INSTRUCTION.
IF_INSTRUCTION  output  32  fetched instruction or NOP_INSTR.
IF_BUSYWAIT  output  1  pipeline stall request (OR'd into pipeline-register HOLD).

Behaviour:
- Reset (RESET=0, async):
  - PC=RESET_PC, DRAIN_ADDR=0, state=FETCH.
  - While RESET=0: IMEM_READ=0, IF_PC=RESET_PC, IF_INSTRUCTION=NOP_INSTR, IF_BUSYWAIT=0.
  - First read is issued in the first cycle after deassertion.
- A fetch completes in any cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0. Zero-wait hit gives one instruction per cycle.
- State FETCH:
  - IMEM_READ=1, IMEM_ADDR=PC, IF_PC=PC.
  - IF_INSTRUCTION = IMEM_INSTRUCTION if complete and BRANCH_TAKEN=0, else NOP_INSTR.
  - IF_BUSYWAIT = IMEM_BUSYWAIT & ~BRANCH_TAKEN.
- State DRAIN (wrong-path access still outstanding):
  - IMEM_READ=1, IMEM_ADDR=DRAIN_ADDR, IF_PC=PC, IF_INSTRUCTION=NOP_INSTR, IF_BUSYWAIT=0.
  - Bubbles flow so the branch leaves EX.
- Next-PC priority at posedge:
  1. BRANCH_TAKEN: PC<=target.
  2. Else HOLD=1, FETCH incomplete, or state=DRAIN: PC holds.
  3. Else PC<=PC+4, mod 2^32 (32'hFFFF_FFFC -> 0).
- Transitions:
  - FETCH, BRANCH_TAKEN, IMEM_BUSYWAIT=1: DRAIN_ADDR<=PC, go to DRAIN.
  - FETCH, BRANCH_TAKEN, fetch complete: stay in FETCH; current instruction squashed to NOP.
  - DRAIN, IMEM_BUSYWAIT=0: go to FETCH; data discarded.
  - DRAIN, BRANCH_TAKEN: PC<=new target; DRAIN_ADDR unchanged; remain in DRAIN unless the drain completes this cycle.
- HOLD with fetch complete: PC not advanced; the same address is re-read next cycle (redundant read permitted).
- HOLD has no effect on squash; BRANCH_TAKEN overrides HOLD.
- No combinational path from IMEM_INSTRUCTION to IMEM_ADDR.

Decomposition:
- Package rv32_if_pkg: fetch-state encoding (FETCH, DRAIN), NOP_INSTR constant, PC-increment constant 4.
- One sub-module, if_pc_unit: PC register, next-PC priority mux, target alignment.
- State machine and output muxing stay in the top.

Test Plan:
1. Reset release with zero-wait memory -> IMEM_ADDR sequence 0x0, 0x4, 0x8; IF_INSTRUCTION equals memory words; IF_BUSYWAIT=0 throughout.
2. Memory busywait 3 cycles at PC=0x10 -> IF_BUSYWAIT=1 for 3 cycles, IMEM_ADDR stable at 0x10, then instruction delivered and PC=0x14.
3. BRANCH_TAKEN target 0x100 on a completing fetch at 0x20 -> IF_INSTRUCTION=0x00000013 that cycle; next IMEM_ADDR=0x100.
4. BRANCH_TAKEN target 0x200 during busywait at 0x30 (2 more busy cycles) -> IF_BUSYWAIT drops immediately; IMEM_ADDR stays 0x30 until done; NOPs emitted; next fetch at 0x200.
5. HOLD=1 for 2 cycles at PC=0x40 -> IF_PC stays 0x40; PC resumes 0x44 after release.
6. PC at 0xFFFFFFFC with zero-wait memory -> next fetch at 0x0; RESET pulsed low mid-busywait -> outputs immediately at reset values, PC=RESET_PC.
